hilo_muldiv_ctrl: RTL and testbench
===================================

Name: hilo_muldiv_ctrl

Overview:
- Multi-cycle sequencer that drives the ALU for MULT/DIV and owns the architectural HI/LO registers.
- Holds the operands stable on the ALU for a fixed number of cycles and captures Result1 into LO and Result2 into HI.
- Raises busy so the pipeline stalls MFHI/MFLO and new MULT/DIV.
- Sits beside the EX stage, between the decode-issued operation and the ALU's mul/div paths.

Parameters:
- MUL_CYCLES, 4, cycles ALU operands are held for MULT before capture (>=1).
- DIV_CYCLES, 8, cycles ALU operands are held for DIV before capture (>=1).
- CNT_W, 4, width of the cycle counter; must hold max(MUL_CYCLES, DIV_CYCLES)-1.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request valid for one cycle; sampled only when ready=1.
- op  in  2  00 MULT, 01 DIV, 10 MTHI, 11 MTLO.
- x  in  32  rs operand.
- y  in  32  rt operand.
- flush  in  1  abort any in-flight MULT/DIV.
- ready  out  1  equals !busy.
- busy  out  1  MULT/DIV in flight.
- done  out  1  one-cycle pulse after HI/LO capture.
- div_zero  out  1  one-cycle pulse with done when DIV divisor was 0.
- hi  out  32  HI register.
- lo  out  32  LO register.
- alu_s  out  4  ALU select.
- alu_x  out  32  ALU X operand.
- alu_y  out  32  ALU Y operand.
- alu_result1  in  32  ALU Result1 (product low / quotient).
- alu_result2  in  32  ALU Result2 (product high / remainder).

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: state=IDLE, cnt=0, op regs=0, hi=0, lo=0, busy=0, done=0, div_zero=0, alu_s=4'b1111, alu_x=0, alu_y=0.
- States:
  - IDLE: ready=1, alu_s=4'b1111 (ALU default, result 0).
  - MUL: alu_s=4'b0011.
  - DIV: alu_s=4'b0100.
- In MUL and DIV, alu_x and alu_y come from registered operands, never live x and y.
- IDLE, start & op=MULT: at edge E0, latch x and y, load cnt=MUL_CYCLES-1, go to MUL.
- IDLE, start & op=DIV: same sequence with DIV_CYCLES-1, go to DIV.
- IDLE, start & op=MTHI: hi<=x at E0. Stay in IDLE, no done.
- IDLE, start & op=MTLO: lo<=x at E0. Stay in IDLE, no done.
- MUL/DIV, cnt!=0: cnt decrements each edge.
- MUL/DIV, cnt==0: at that edge lo<=alu_result1, hi<=alu_result2, done<=1 for one cycle, go to IDLE.
- Latency: busy is high for exactly N cycles (N = MUL_CYCLES or DIV_CYCLES). The new hi/lo are visible in the same cycle done is high.
- Division by zero (latched y==0): hi/lo are NOT written. done and div_zero pulse together.
- start while busy: ignored, no queueing. The requester must hold its request until ready.
- flush:
  - In MUL/DIV: return to IDLE at the next edge, hi/lo unchanged, no done.
  - In IDLE: no effect.
  - flush has priority over completion on the same edge.
- flush & start in IDLE on the same edge: flush wins; the start is dropped.
- rst mid-operation: immediate return to reset values; the operation is lost.
- All arithmetic is unsigned (ALU mul/div sign input tied 0); no width extension here.
- Counter: never wraps; it is reloaded only from IDLE.
- Outputs: all are registered except ready and busy, which decode state.

Decomposition:
- Shared package mips_alu_pkg:
  - ALU select constants: ALU_SLL, ALU_SRA, ALU_SRL, ALU_MUL=4'b0011, ALU_DIV=4'b0100, ... , ALU_NOP=4'b1111.
  - HILO op codes: HILO_MULT, HILO_DIV, HILO_MTHI, HILO_MTLO.
  - State encoding: IDLE, MUL, DIV.
- Sub-module: none. The counter and FSM are small enough to stay inline.

Test Plan:
- MULT x=0x00010000, y=0x00010000 → busy for 4 cycles, then done; hi=0x00000001, lo=0x00000000; alu_s=0011 throughout busy.
- DIV x=100, y=7 → busy for 8 cycles, then done; lo=14, hi=2. Changing x/y during busy has no effect on the result.
- DIV x=5, y=0, with prior hi=0xAAAA0000 and lo=0x5555 → done and div_zero pulse together; hi/lo unchanged.
- MTHI x=0x12345678, then MTLO x=0x9 → hi=0x12345678 and lo=0x9 one cycle after each start; busy never asserted.
- MULT started, then start & op=DIV at cycle 2 → DIV ignored. Only the MULT result is written; exactly one done pulse.
- Tests for flush and rst mid-operation:
  - MULT started, flush at cycle 2 → IDLE next cycle, no done, hi/lo unchanged.
  - A repeat MULT run with rst asserted at cycle 3 → all outputs at reset values immediately.

Source files
------------

// File: rtl/mips_alu_pkg.sv
// Shared ALU select codes, HI/LO operation codes and sequencer state encoding
// used by the MULT/DIV controller that sits beside the EX stage.
package mips_alu_pkg;

  // ALU select codes driven onto alu_s
  localparam logic [3:0] ALU_SLL = 4'b0000;
  localparam logic [3:0] ALU_SRA = 4'b0001;
  localparam logic [3:0] ALU_SRL = 4'b0010;
  localparam logic [3:0] ALU_MUL = 4'b0011;
  localparam logic [3:0] ALU_DIV = 4'b0100;
  localparam logic [3:0] ALU_NOP = 4'b1111;

  // Operation codes issued by decode on the op port
  typedef enum logic [1:0] {
    HILO_MULT = 2'b00,
    HILO_DIV  = 2'b01,
    HILO_MTHI = 2'b10,
    HILO_MTLO = 2'b11
  } hilo_op_e;

  // Sequencer state
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    MUL  = 2'b01,
    DIV  = 2'b10
  } hilo_state_e;

  // ALU select that belongs to a given sequencer state
  function automatic logic [3:0] alu_sel_for(input hilo_state_e st);
    case (st)
      MUL:     return ALU_MUL;
      DIV:     return ALU_DIV;
      default: return ALU_NOP;
    endcase
  endfunction

endpackage

// File: rtl/hilo_muldiv_ctrl.sv
// Multi-cycle MULT/DIV sequencer. Holds latched operands on the ALU for a
// fixed number of cycles, then captures Result1 into LO and Result2 into HI.
// Also services MTHI/MTLO directly from IDLE.
module hilo_muldiv_ctrl
  import mips_alu_pkg::*;
#(
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 8,
  parameter int CNT_W      = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] x,
  input  logic [31:0] y,
  input  logic        flush,
  output logic        ready,
  output logic        busy,
  output logic        done,
  output logic        div_zero,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [3:0]  alu_s,
  output logic [31:0] alu_x,
  output logic [31:0] alu_y,
  input  logic [31:0] alu_result1,
  input  logic [31:0] alu_result2
);

  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

  hilo_state_e      state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [31:0]      hi_reg, hi_next;
  logic [31:0]      lo_reg, lo_next;
  logic [31:0]      alu_x_reg, alu_x_next;
  logic [31:0]      alu_y_reg, alu_y_next;
  logic [3:0]       alu_s_reg, alu_s_next;
  logic             done_reg, done_next;
  logic             div_zero_reg, div_zero_next;

  // State, counter, operand and HI/LO registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      hi_reg       <= '0;
      lo_reg       <= '0;
      alu_x_reg    <= '0;
      alu_y_reg    <= '0;
      alu_s_reg    <= ALU_NOP;
      done_reg     <= 1'b0;
      div_zero_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      hi_reg       <= hi_next;
      lo_reg       <= lo_next;
      alu_x_reg    <= alu_x_next;
      alu_y_reg    <= alu_y_next;
      alu_s_reg    <= alu_s_next;
      done_reg     <= done_next;
      div_zero_reg <= div_zero_next;
    end
  end

  // Next-state and register-input decode; flush beats both start and completion
  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    hi_next       = hi_reg;
    lo_next       = lo_reg;
    alu_x_next    = alu_x_reg;
    alu_y_next    = alu_y_reg;
    done_next     = 1'b0;
    div_zero_next = 1'b0;

    case (state_reg)
      IDLE: begin
        if (start && !flush) begin
          case (hilo_op_e'(op))
            HILO_MULT: begin
              state_next = MUL;
              cnt_next   = MUL_LOAD;
              alu_x_next = x;
              alu_y_next = y;
            end
            HILO_DIV: begin
              state_next = DIV;
              cnt_next   = DIV_LOAD;
              alu_x_next = x;
              alu_y_next = y;
            end
            HILO_MTHI: hi_next = x;
            HILO_MTLO: lo_next = x;
            default: ;
          endcase
        end
      end

      MUL, DIV: begin
        if (flush) begin
          state_next = IDLE;
          alu_x_next = '0;
          alu_y_next = '0;
        end else if (cnt_reg != '0) begin
          cnt_next = cnt_reg - CNT_W'(1);
        end else begin
          // A zero divisor leaves HI/LO untouched and flags the condition instead
          if (state_reg == DIV && alu_y_reg == '0) begin
            div_zero_next = 1'b1;
          end else begin
            lo_next = alu_result1;
            hi_next = alu_result2;
          end
          done_next  = 1'b1;
          state_next = IDLE;
          alu_x_next = '0;
          alu_y_next = '0;
        end
      end

      default: state_next = IDLE;
    endcase

    // alu_s is registered, so it is decoded from the state being entered
    alu_s_next = alu_sel_for(state_next);
  end

  assign busy     = (state_reg != IDLE);
  assign ready    = !busy;
  assign done     = done_reg;
  assign div_zero = div_zero_reg;
  assign hi       = hi_reg;
  assign lo       = lo_reg;
  assign alu_s    = alu_s_reg;
  assign alu_x    = alu_x_reg;
  assign alu_y    = alu_y_reg;

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Bench for hilo_muldiv_ctrl: a behavioural ALU answers alu_s/alu_x/alu_y,
// expected HI/LO/div_zero results are queued at issue and popped on done.
module tb_hilo_muldiv_ctrl;
  import mips_alu_pkg::*;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] x = '0;
  logic [31:0] y = '0;
  logic        flush = 1'b0;
  logic        ready, busy, done, div_zero;
  logic [31:0] hi, lo, alu_x, alu_y;
  logic [3:0]  alu_s;
  logic [31:0] alu_result1, alu_result2;

  int   checks = 0;
  int   failures = 0;
  exp_t sb[$];
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  always #5 clk = ~clk;

  hilo_muldiv_ctrl #(
    .MUL_CYCLES(4),
    .DIV_CYCLES(8),
    .CNT_W(4)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .x(x), .y(y), .flush(flush),
    .ready(ready), .busy(busy), .done(done), .div_zero(div_zero),
    .hi(hi), .lo(lo), .alu_s(alu_s), .alu_x(alu_x), .alu_y(alu_y),
    .alu_result1(alu_result1), .alu_result2(alu_result2)
  );

  // Behavioural unsigned ALU for the mul/div paths
  always_comb begin
    alu_result1 = '0;
    alu_result2 = '0;
    if (alu_s == ALU_MUL) begin
      {alu_result2, alu_result1} = 64'(alu_x) * 64'(alu_y);
    end else if (alu_s == ALU_DIV && alu_y != '0) begin
      alu_result1 = alu_x / alu_y;
      alu_result2 = alu_x % alu_y;
    end
  end

  // Present a request for one edge; returns at the falling edge after it
  task automatic do_start(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1; op = o; x = a; y = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Observe until done (bounded); scrambles x/y to prove operands are latched
  task automatic run_until_done(output int busy_cyc, output bit got_done,
                                output logic [3:0] s0, output logic [31:0] x0,
                                output logic [31:0] y0, output bit changed);
    busy_cyc = 0; got_done = 0; changed = 0;
    s0 = alu_s; x0 = alu_x; y0 = alu_y;
    for (int i = 0; i < 40; i++) begin
      if (done) begin
        got_done = 1;
        break;
      end
      if (busy) begin
        busy_cyc++;
        if (alu_s !== s0 || alu_x !== x0 || alu_y !== y0) changed = 1;
      end
      x = $urandom; y = $urandom;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({hi, lo} !== 64'h0) begin
      failures++; $display("FAIL reset_hilo got=%h expected=0", {hi, lo});
    end
    checks++;
    if ({busy, ready, done, div_zero} !== 4'b0100) begin
      failures++; $display("FAIL reset_flags got=%b expected=0100", {busy, ready, done, div_zero});
    end
    checks++;
    if ({alu_s, alu_x, alu_y} !== {ALU_NOP, 64'h0}) begin
      failures++; $display("FAIL reset_alu got=%h expected=%h", {alu_s, alu_x, alu_y}, {ALU_NOP, 64'h0});
    end
    rst = 1'b0;
    @(negedge clk);
    $display("txn reset done");
  endtask

  task automatic test_mthi_mtlo;
    do_start(HILO_MTHI, 32'h1234_5678, 32'h0);
    checks++;
    if (hi !== 32'h1234_5678 || busy !== 1'b0 || done !== 1'b0) begin
      failures++; $display("FAIL mthi got hi=%h busy=%b done=%b expected hi=12345678 busy=0 done=0", hi, busy, done);
    end
    do_start(HILO_MTLO, 32'h9, 32'h0);
    checks++;
    if (lo !== 32'h9 || hi !== 32'h1234_5678 || busy !== 1'b0 || done !== 1'b0) begin
      failures++; $display("FAIL mtlo got hi=%h lo=%h busy=%b done=%b expected 12345678/9/0/0", hi, lo, busy, done);
    end
    m_hi = 32'h1234_5678; m_lo = 32'h9;
    $display("txn mthi/mtlo hi=%h lo=%h", hi, lo);
  endtask

  task automatic test_muldiv;
    logic [1:0]  o;
    logic [31:0] a, b, eh, el;
    logic        ez;
    int          ec;
    logic [3:0]  es, s0;
    logic [31:0] x0, y0;
    int          bc;
    bit          got, chg;
    exp_t        e;
    for (int k = 0; k < 4; k++) begin
      o = HILO_MULT; a = '0; b = '0; eh = '0; el = '0; ez = 1'b0; ec = 4; es = ALU_MUL;
      case (k)
        0: begin a = 32'h0001_0000; b = 32'h0001_0000; eh = 32'h1; el = 32'h0; end
        1: begin o = HILO_DIV; a = 32'd100; b = 32'd7; eh = 32'd2; el = 32'd14; ec = 8; es = ALU_DIV; end
        2: begin a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; eh = 32'hFFFF_FFFE; el = 32'h1; end
        default: begin
          do_start(HILO_MTHI, 32'hAAAA_0000, 32'h0);
          do_start(HILO_MTLO, 32'h0000_5555, 32'h0);
          o = HILO_DIV; a = 32'd5; b = 32'd0; eh = 32'hAAAA_0000; el = 32'h0000_5555;
          ez = 1'b1; ec = 8; es = ALU_DIV;
        end
      endcase
      sb.push_back(exp_t'({eh, el, ez}));
      do_start(o, a, b);
      run_until_done(bc, got, s0, x0, y0, chg);
      checks++;
      if (!got) begin
        failures++; $display("FAIL muldiv%0d_done got=no done expected=done", k);
      end
      checks++;
      if (bc != ec) begin
        failures++; $display("FAIL muldiv%0d_busy got=%0d cycles expected=%0d", k, bc, ec);
      end
      checks++;
      if (s0 !== es || x0 !== a || y0 !== b || chg) begin
        failures++; $display("FAIL muldiv%0d_alu got s=%b x=%h y=%h changed=%0d expected s=%b x=%h y=%h changed=0",
                             k, s0, x0, y0, chg, es, a, b);
      end
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if (hi !== e.hi || lo !== e.lo || div_zero !== e.dz) begin
          failures++; $display("FAIL muldiv%0d_result got hi=%h lo=%h dz=%b expected hi=%h lo=%h dz=%b",
                               k, hi, lo, div_zero, e.hi, e.lo, e.dz);
        end
        m_hi = e.hi; m_lo = e.lo;
      end
      $display("txn op=%0d x=%h y=%h hi=%h lo=%h dz=%b busy_cycles=%0d", o, a, b, hi, lo, div_zero, bc);
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || div_zero !== 1'b0) begin
        failures++; $display("FAIL muldiv%0d_pulse got done=%b dz=%b expected 0/0", k, done, div_zero);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [3:0]  s0;
    logic [31:0] x0, y0;
    int          bc, extra;
    bit          got, chg;
    exp_t        e;
    sb.push_back(exp_t'({32'h0, 32'd15, 1'b0}));
    do_start(HILO_MULT, 32'd3, 32'd5);
    @(negedge clk);
    start = 1'b1; op = HILO_DIV; x = 32'd1000; y = 32'd3;
    @(negedge clk);
    start = 1'b0;
    run_until_done(bc, got, s0, x0, y0, chg);
    checks++;
    if (!got || bc != 2) begin
      failures++; $display("FAIL b2b_timing got done=%0d busy_left=%0d expected done=1 busy_left=2", got, bc);
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (hi !== e.hi || lo !== e.lo) begin
        failures++; $display("FAIL b2b_result got hi=%h lo=%h expected hi=%h lo=%h", hi, lo, e.hi, e.lo);
      end
      m_hi = e.hi; m_lo = e.lo;
    end
    extra = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done || busy) extra++;
    end
    checks++;
    if (extra != 0 || alu_s !== ALU_NOP) begin
      failures++; $display("FAIL b2b_ignored got extra_activity=%0d alu_s=%b expected 0/1111", extra, alu_s);
    end
    $display("txn back_to_back hi=%h lo=%h extra=%0d", hi, lo, extra);
  endtask

  task automatic test_flush;
    int seen;
    // flush mid-operation
    do_start(HILO_MULT, 32'd7, 32'd9);
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || alu_s !== ALU_NOP || hi !== m_hi || lo !== m_lo) begin
      failures++; $display("FAIL flush_mid got busy=%b done=%b s=%b hi=%h lo=%h expected 0/0/1111/%h/%h",
                           busy, done, alu_s, hi, lo, m_hi, m_lo);
    end
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done) seen++;
    end
    checks++;
    if (seen != 0) begin
      failures++; $display("FAIL flush_nodone got done_pulses=%0d expected=0", seen);
    end
    // flush on the completion edge
    do_start(HILO_MULT, 32'd7, 32'd9);
    repeat (3) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || hi !== m_hi || lo !== m_lo) begin
      failures++; $display("FAIL flush_at_done got done=%b busy=%b hi=%h lo=%h expected 0/0/%h/%h",
                           done, busy, hi, lo, m_hi, m_lo);
    end
    // flush together with start in IDLE
    @(negedge clk);
    start = 1'b1; flush = 1'b1; op = HILO_MTHI; x = 32'hDEAD_BEEF;
    @(negedge clk);
    op = HILO_MULT; x = 32'd2; y = 32'd2;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    checks++;
    if (hi !== m_hi || busy !== 1'b0) begin
      failures++; $display("FAIL flush_start got hi=%h busy=%b expected hi=%h busy=0", hi, busy, m_hi);
    end
    $display("txn flush hi=%h lo=%h", hi, lo);
  endtask

  task automatic test_rst_mid;
    logic [3:0]  s0;
    logic [31:0] x0, y0;
    int          bc;
    bit          got, chg;
    exp_t        e;
    do_start(HILO_MTHI, 32'hCAFE_0000, 32'h0);
    do_start(HILO_MULT, 32'h0001_0000, 32'h0001_0000);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if ({hi, lo} !== 64'h0 || {busy, ready, done, div_zero} !== 4'b0100) begin
      failures++; $display("FAIL rst_mid_state got hi=%h lo=%h flags=%b expected 0/0/0100",
                           hi, lo, {busy, ready, done, div_zero});
    end
    checks++;
    if ({alu_s, alu_x, alu_y} !== {ALU_NOP, 64'h0}) begin
      failures++; $display("FAIL rst_mid_alu got=%h expected=%h", {alu_s, alu_x, alu_y}, {ALU_NOP, 64'h0});
    end
    @(negedge clk);
    rst = 1'b0;
    // operation after reset still works
    sb.push_back(exp_t'({32'h0, 32'd42, 1'b0}));
    do_start(HILO_MULT, 32'd6, 32'd7);
    run_until_done(bc, got, s0, x0, y0, chg);
    checks++;
    if (!got || bc != 4) begin
      failures++; $display("FAIL rst_after_timing got done=%0d busy=%0d expected done=1 busy=4", got, bc);
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (hi !== e.hi || lo !== e.lo) begin
        failures++; $display("FAIL rst_after_result got hi=%h lo=%h expected hi=%h lo=%h", hi, lo, e.hi, e.lo);
      end
    end
    $display("txn rst_mid then mult hi=%h lo=%h", hi, lo);
  endtask

  initial begin
    test_reset();
    test_mthi_mtlo();
    test_muldiv();
    test_back_to_back();
    test_flush();
    test_rst_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
